// File: rtl/ysyx_20020207_writeback.sv
// ---------------------------------------------------------------------------
// ysyx_20020207_writeback
//
// Writeback stage. Accepts one retiring instruction from the EXU. For a load
// it waits for the LSU data, then sign/zero-extends it. It then drives the
// register-file write port for exactly one cycle. Only one instruction is in
// flight at a time.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   EXU handshake; an instruction is accepted on valid & ready
//   in_rd, in_rd_wen destination register and its write enable
//   in_alu_res       result for non-load instructions
//   in_is_load       result comes from the LSU
//   in_ld_funct      RV32I load funct3 (lb/lh/lw/lbu/lhu; others act as lw)
//   in_addr_lo       load address bits [1:0], selects the byte/half lane
//   lsu_rvalid/rdata LSU load data (1-cycle pulse, word-aligned bus data)
//   wb_finish        commit strobe, 1-cycle pulse per retired instruction
//   wb_wen/waddr/wdata register write port; these hold their values between
//                    commits and are only meaningful while wb_finish is high
//   wb_busy          an instruction is being held (waiting on LSU or committing)
//
// Optional feature, macro YSYX_WB_RETIRE_CNT_EN:
//   wb_retire_cnt[63:0]  counts commit cycles, wraps
//   wb_load_stall[31:0]  counts cycles spent waiting on the LSU, saturates
// ---------------------------------------------------------------------------
module ysyx_20020207_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic                  in_is_load,
  input  logic [2:0]            in_ld_funct,
  input  logic [1:0]            in_addr_lo,
  input  logic                  lsu_rvalid,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  wb_finish,
  output logic                  wb_wen,
  output logic [ADDR_WIDTH-1:0] wb_waddr,
  output logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  wb_busy
`ifdef YSYX_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           wb_retire_cnt,
  output logic [31:0]           wb_load_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_LSU = 2'd1,
    S_COMMIT   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Instruction fields captured at the handshake (needed by the load path).
  logic [ADDR_WIDTH-1:0] r_rd;
  logic                  r_rd_wen;
  logic [2:0]            r_funct;
  logic [1:0]            r_addr_lo;

  logic                  r_wb_wen;
  logic [ADDR_WIDTH-1:0] r_wb_waddr;
  logic [DATA_WIDTH-1:0] r_wb_wdata;

  logic                  w_hs;
  logic                  w_commit_alu;
  logic                  w_commit_ld;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ld_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    wb_finish    = 1'b0;
    wb_busy      = 1'b1;
    w_hs         = 1'b0;
    w_commit_alu = 1'b0;
    w_commit_ld  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        wb_busy  = 1'b0;
        if (in_valid) begin
          w_hs = 1'b1;
          if (in_is_load) begin
            w_state_next = S_WAIT_LSU;
          end else begin
            // Non-load results are known now; load the write port directly.
            w_commit_alu = 1'b1;
            w_state_next = S_COMMIT;
          end
        end
      end
      S_WAIT_LSU: begin
        // Any lsu_rvalid seen in other states is deliberately ignored.
        if (lsu_rvalid) begin
          w_commit_ld  = 1'b1;
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        wb_finish    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        wb_busy      = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- load extension
  always_comb begin
    w_byte = 8'd0;
    case (r_addr_lo)
      2'd0: w_byte = lsu_rdata[7:0];
      2'd1: w_byte = lsu_rdata[15:8];
      2'd2: w_byte = lsu_rdata[23:16];
      2'd3: w_byte = lsu_rdata[31:24];
      default: w_byte = 8'd0;
    endcase
  end

  // Halfword lane depends only on addr bit 1; bit 0 is not used for halves.
  assign w_half = r_addr_lo[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];

  always_comb begin
    w_ld_data = lsu_rdata;
    case (r_funct)
      3'b000:  w_ld_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_ld_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_ld_data = lsu_rdata;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd      <= '0;
      r_rd_wen  <= 1'b0;
      r_funct   <= 3'd0;
      r_addr_lo <= 2'd0;
    end else if (w_hs) begin
      r_rd      <= in_rd;
      r_rd_wen  <= in_rd_wen;
      r_funct   <= in_ld_funct;
      r_addr_lo <= in_addr_lo;
    end
  end

  // Write port is updated only on entry to COMMIT; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_wen   <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_wdata <= '0;
    end else if (w_commit_alu) begin
      r_wb_wen   <= in_rd_wen & (in_rd != '0);
      r_wb_waddr <= in_rd;
      r_wb_wdata <= in_alu_res;
    end else if (w_commit_ld) begin
      r_wb_wen   <= r_rd_wen & (r_rd != '0);
      r_wb_waddr <= r_rd;
      r_wb_wdata <= w_ld_data;
    end
  end

  assign wb_wen   = r_wb_wen;
  assign wb_waddr = r_wb_waddr;
  assign wb_wdata = r_wb_wdata;

`ifdef YSYX_WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;
  logic [31:0] r_load_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= 64'd0;
      r_load_stall <= 32'd0;
    end else begin
      if (r_state == S_COMMIT) begin
        r_retire_cnt <= r_retire_cnt + 64'd1;
      end
      if ((r_state == S_WAIT_LSU) && (r_load_stall != 32'hFFFF_FFFF)) begin
        r_load_stall <= r_load_stall + 32'd1;
      end
    end
  end

  assign wb_retire_cnt = r_retire_cnt;
  assign wb_load_stall = r_load_stall;
`endif

endmodule

// File: tb/tb_ysyx_20020207_writeback.sv
// ---------------------------------------------------------------------------
// tb_ysyx_20020207_writeback
//
// Self-checking bench for the writeback stage: a table of directed vectors,
// hand-written multi-cycle sequences (back-to-back accepts, stray LSU pulse,
// reset during a load wait) and randomized transactions checked against a
// behavioural load-extension model.
// ---------------------------------------------------------------------------
module tb_ysyx_20020207_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [31:0] in_alu_res;
  logic        in_is_load;
  logic [2:0]  in_ld_funct;
  logic [1:0]  in_addr_lo;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        wb_finish;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_busy;
`ifdef YSYX_WB_RETIRE_CNT_EN
  logic [63:0] wb_retire_cnt;
  logic [31:0] wb_load_stall;
`endif

  ysyx_20020207_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_rd_wen   (in_rd_wen),
    .in_alu_res  (in_alu_res),
    .in_is_load  (in_is_load),
    .in_ld_funct (in_ld_funct),
    .in_addr_lo  (in_addr_lo),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rdata   (lsu_rdata),
    .wb_finish   (wb_finish),
    .wb_wen      (wb_wen),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .wb_busy     (wb_busy)
`ifdef YSYX_WB_RETIRE_CNT_EN
    ,
    .wb_retire_cnt (wb_retire_cnt),
    .wb_load_stall (wb_load_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  longint exp_retire;
  longint exp_stall;

  typedef struct {
    logic        ld;
    logic [2:0]  f;
    logic [1:0]  alo;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          wait_n;
    logic [31:0] exp_data;
    logic        exp_wen;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference load extension from the RV32I rules, using plain arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [1:0] alo,
                                             input logic [31:0] d);
    int unsigned b;
    int unsigned h;
    int unsigned ai;
    ai = alo;
    b  = (d >> (8 * ai)) % 256;
    h  = (d >> (16 * (ai / 2))) % 65536;
    case (f)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready"},  in_ready,  1'b1);
    chk({tag, " finish"}, wb_finish, 1'b0);
    chk({tag, " wen"},    wb_wen,    1'b0);
    chk({tag, " waddr"},  wb_waddr,  5'd0);
    chk({tag, " wdata"},  wb_wdata,  32'd0);
    chk({tag, " busy"},   wb_busy,   1'b0);
  endtask

  // One full transaction, starting and ending at a falling edge in IDLE.
  task automatic run_txn(input string name, input logic ld, input logic [2:0] f,
                         input logic [1:0] alo, input logic [4:0] rd, input logic wen,
                         input logic [31:0] alu, input logic [31:0] rdata, input int wait_n,
                         input logic [31:0] exp_data, input logic exp_wen);
    int busy_n;
    chk({name, " ready_idle"}, in_ready, 1'b1);
    in_valid    = 1'b1;
    in_is_load  = ld;
    in_ld_funct = f;
    in_addr_lo  = alo;
    in_rd       = rd;
    in_rd_wen   = wen;
    in_alu_res  = alu;
    @(negedge clk);
    in_valid   = 1'b0;
    in_alu_res = $urandom;
    busy_n     = 0;
    if (ld) begin
      for (int i = 0; i < wait_n; i++) begin
        chk({name, " wait_finish"}, wb_finish, 1'b0);
        chk({name, " wait_ready"},  in_ready,  1'b0);
        if (wb_busy) busy_n++;
        lsu_rvalid = (i == wait_n - 1);
        lsu_rdata  = (i == wait_n - 1) ? rdata : $urandom;
        @(negedge clk);
      end
      lsu_rvalid = 1'b0;
      lsu_rdata  = $urandom;
      exp_stall += wait_n;
    end
    if (wb_busy) busy_n++;
    chk({name, " finish"}, wb_finish, 1'b1);
    chk({name, " wen"},    wb_wen,    exp_wen);
    chk({name, " waddr"},  wb_waddr,  rd);
    chk({name, " wdata"},  wb_wdata,  exp_data);
    exp_retire++;
    @(negedge clk);
    chk({name, " finish_drop"}, wb_finish, 1'b0);
    chk({name, " ready_back"},  in_ready,  1'b1);
    chk({name, " wdata_hold"},  wb_wdata,  exp_data);
    chk({name, " busy_cycles"}, busy_n,    ld ? wait_n + 1 : 1);
    $display("txn %s ld=%0b f=%0d alo=%0d rd=%0d wdata=%08h wen=%0b", name, ld, f, alo, rd,
             wb_wdata, wb_wen);
  endtask

  initial begin
    logic [31:0] pre_alu;
    int          pulses;
    logic [2:0]  fsel[8];
    n_pass      = 0;
    n_total     = 0;
    exp_retire  = 0;
    exp_stall   = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_rd       = 5'd0;
    in_rd_wen   = 1'b0;
    in_alu_res  = 32'd0;
    in_is_load  = 1'b0;
    in_ld_funct = 3'd0;
    in_addr_lo  = 2'd0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = 32'd0;
    fsel = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    //            ld    f     alo  rd     wen  alu            rdata          wait exp_data      exp_wen
    vecs[0] = '{1'b0, 3'd0, 2'd0, 5'd5,  1'b1, 32'h1234_5678, 32'h0,         0, 32'h1234_5678, 1'b1};
    vecs[1] = '{1'b1, 3'd0, 2'd2, 5'd10, 1'b1, 32'h0,         32'h0080_0000, 3, 32'hFFFF_FF80, 1'b1};
    vecs[2] = '{1'b1, 3'd5, 2'd2, 5'd3,  1'b1, 32'h0,         32'hBEEF_0000, 1, 32'h0000_BEEF, 1'b1};
    vecs[3] = '{1'b1, 3'd1, 2'd0, 5'd31, 1'b1, 32'h0,         32'h0000_8001, 2, 32'hFFFF_8001, 1'b1};
    vecs[4] = '{1'b0, 3'd0, 2'd0, 5'd0,  1'b1, 32'hDEAD_BEEF, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{1'b1, 3'd2, 2'd1, 5'd8,  1'b0, 32'h0,         32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0};
    vecs[6] = '{1'b1, 3'd4, 2'd3, 5'd1,  1'b1, 32'h0,         32'h9A00_0000, 1, 32'h0000_009A, 1'b1};
    vecs[7] = '{1'b1, 3'd3, 2'd0, 5'd2,  1'b1, 32'h0,         32'h1122_3344, 2, 32'h1122_3344, 1'b1};
    vecs[8] = '{1'b1, 3'd1, 2'd3, 5'd4,  1'b1, 32'h0,         32'h7FFF_0000, 1, 32'h0000_7FFF, 1'b1};
    vecs[9] = '{1'b1, 3'd0, 2'd1, 5'd6,  1'b1, 32'h0,         32'h0000_7F00, 4, 32'h0000_007F, 1'b1};

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int v = 0; v < 10; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].ld, vecs[v].f, vecs[v].alo, vecs[v].rd,
              vecs[v].wen, vecs[v].alu, vecs[v].rdata, vecs[v].wait_n, vecs[v].exp_data,
              vecs[v].exp_wen);
    end

    // Stray LSU pulse in IDLE must do nothing.
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    lsu_rvalid = 1'b0;
    chk("stray busy",   wb_busy,   1'b0);
    chk("stray finish", wb_finish, 1'b0);
    chk("stray ready",  in_ready,  1'b1);
    chk("stray wdata",  wb_wdata,  32'h0000_007F);
    $display("txn stray_rvalid busy=%0b finish=%0b", wb_busy, wb_finish);

    // in_valid held high over three ALU ops: finish on alternate cycles.
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    in_rd      = 5'd7;
    in_rd_wen  = 1'b1;
    in_alu_res = 32'hA000_0001;
    pulses     = 0;
    for (int j = 1; j <= 6; j++) begin
      pre_alu = in_alu_res;
      @(negedge clk);
      chk($sformatf("b2b finish c%0d", j), wb_finish, (j % 2 == 1) ? 1'b1 : 1'b0);
      if (wb_finish) begin
        pulses++;
        chk($sformatf("b2b wdata c%0d", j), wb_wdata, pre_alu);
      end
      in_alu_res = $urandom;
      if (j == 5) in_valid = 1'b0;
    end
    chk("b2b pulses", pulses, 3);
    exp_retire += 3;
    $display("txn back_to_back pulses=%0d", pulses);

    // Reset asserted while waiting on the LSU: instruction is discarded.
    in_valid    = 1'b1;
    in_is_load  = 1'b1;
    in_ld_funct = 3'd2;
    in_rd       = 5'd9;
    in_rd_wen   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid busy_before", wb_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid async");
    @(negedge clk);
    rst_n      = 1'b1;
    exp_retire = 0;
    exp_stall  = 0;
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h7777_7777;
    @(negedge clk);
    lsu_rvalid = 1'b0;
    chk("rst_mid finish1", wb_finish, 1'b0);
    chk("rst_mid ready",   in_ready,  1'b1);
    chk("rst_mid busy",    wb_busy,   1'b0);
    @(negedge clk);
    chk("rst_mid finish2", wb_finish, 1'b0);
    chk("rst_mid wen",     wb_wen,    1'b0);
    $display("txn reset_during_wait finish=%0b ready=%0b", wb_finish, in_ready);

    // Three ALU ops and one load with two wait cycles.
    run_txn("cnt_alu0", 1'b0, 3'd0, 2'd0, 5'd11, 1'b1, 32'h0000_0011, 32'h0, 0, 32'h0000_0011, 1'b1);
    run_txn("cnt_alu1", 1'b0, 3'd0, 2'd0, 5'd0,  1'b1, 32'h0000_0022, 32'h0, 0, 32'h0000_0022, 1'b0);
    run_txn("cnt_alu2", 1'b0, 3'd0, 2'd0, 5'd12, 1'b0, 32'h0000_0033, 32'h0, 0, 32'h0000_0033, 1'b0);
    run_txn("cnt_ld",   1'b1, 3'd2, 2'd0, 5'd13, 1'b1, 32'h0, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b1);
`ifdef YSYX_WB_RETIRE_CNT_EN
    chk("cnt retire", wb_retire_cnt, 64'd4);
    chk("cnt stall",  wb_load_stall, 64'd2);
`endif

    // Randomized transactions against the behavioural model.
    for (int k = 0; k < 40; k++) begin
      logic        ld;
      logic [2:0]  f;
      logic [1:0]  alo;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] alu;
      logic [31:0] rdata;
      int          wn;
      ld    = 1'($urandom_range(0, 1));
      f     = fsel[$urandom_range(0, 7)];
      alo   = 2'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 31));
      wen   = 1'($urandom_range(0, 1));
      alu   = $urandom;
      rdata = $urandom;
      wn    = $urandom_range(1, 4);
      run_txn($sformatf("rnd%0d", k), ld, f, alo, rd, wen, alu, rdata, wn,
              ld ? model_load(f, alo, rdata) : alu, wen && (rd != 5'd0));
    end
`ifdef YSYX_WB_RETIRE_CNT_EN
    chk("final retire", wb_retire_cnt, 64'(exp_retire));
    chk("final stall",  wb_load_stall, 64'(exp_stall));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
